// File: rtl/ahb_lite_sram_slave_p.sv
// AHB-lite slave backed by a register-array memory, with wait states,
// byte/half/word lanes, two-cycle ERROR response and saturating error count.
//   in : hclk hreset hsel haddr htrans hwrite hsize hburst hprot hwdata hready_in
//   out: hrdata hreadyout hresp err_count
module ahb_lite_sram_slave_p #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0,
  parameter int ERRCNT_W    = 8
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                hsel,
  input  logic [ADDR_W-1:0]   haddr,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [2:0]          hburst,
  input  logic [3:0]          hprot,
  input  logic [DATA_W-1:0]   hwdata,
  input  logic                hready_in,
  output logic [DATA_W-1:0]   hrdata,
  output logic                hreadyout,
  output logic                hresp,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ERR1, S_ERR2
  } state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              dph;
  logic              d_wr;
  logic [IW-1:0]     d_idx;
  logic [LB-1:0]     d_off;
  logic [2:0]        d_size;
  logic [NB-1:0]     be;
  logic              accept, legal, done;
  logic [LB-1:0]     amask;
  logic [DATA_W-1:0] mem [DEPTH];

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot};

  // Offset bits that must be zero for an access of size sz.
  function automatic logic [LB-1:0] lmask(input logic [2:0] sz);
    logic [LB-1:0] m;
    m = '0;
    for (int i = 0; i < LB; i++)
      m[i] = (sz > 3'(i));
    return m;
  endfunction

  assign accept = hsel & htrans[1] & hready_in;
  assign amask  = lmask(hsize);
  assign legal  = (hsize <= 3'(LB))
               && ((haddr[LB-1:0] & amask) == '0)
               && ((haddr >> (LB + IW)) == '0);

  // Legal data phase finishing this cycle.
  assign done = dph & ((state == S_IDLE) |
                       ((state == S_WAIT) & (cnt == 4'd0)));

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_WAIT: begin
        if (cnt != 4'd0) begin
          hreadyout = 1'b0;
          cnt_nx    = cnt - 4'd1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nx  = S_ERR2;
      end
      S_ERR2: begin
        hresp    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (accept) begin
      if (!legal) begin
        state_nx = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_nx = S_WAIT;
        cnt_nx   = 4'(WAIT_STATES);
      end else begin
        state_nx = S_IDLE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      dph       <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept)
        dph <= legal;
      else if (done)
        dph <= 1'b0;
      if (accept && !legal && !(&err_count))
        err_count <= err_count + 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (accept) begin
      d_wr   <= hwrite;
      d_idx  <= haddr[LB+IW-1:LB];
      d_off  <= haddr[LB-1:0];
      d_size <= hsize;
    end
  end

  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++)
      be[b] = ((LB'(b) ^ d_off) & ~lmask(d_size)) == '0;
  end

  always_ff @(posedge hclk) begin
    if (!hreset && done && d_wr) begin
      for (int b = 0; b < NB; b++)
        if (be[b])
          mem[d_idx][8*b +: 8] <= hwdata[8*b +: 8];
    end
  end

  assign hrdata = (done && !d_wr) ? mem[d_idx] : '0;

endmodule
